control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL take parameter IR_W, default 32: instruction register width.
REQ-002 SHALL take parameter OPCODE_W, default 5: opcode = ir[IR_W-1 -: OPCODE_W].
REQ-003 SHALL take parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready (1..255).
REQ-004 SHALL take parameter COUNT_W, default 16: width of the instruction counter.
REQ-005 SHALL have one clock and asynchronous active-low reset: clock, input, 1, rising-edge clock.
REQ-006 SHALL have clear, input, 1, asynchronous active-low reset.
REQ-007 SHALL have start, input, 1, leave IDLE and begin fetching.
REQ-008 SHALL have stop, input, 1, return to IDLE at the next instruction boundary.
REQ-009 SHALL have ir, input, IR_W, instruction register contents, valid from the cycle after IRin.
REQ-010 SHALL have mem_ready, input, 1, memory read/write completion.
REQ-011 SHALL have datapath strobes as 1-bit outputs: PCout PCin IncPC MARin MDRin MDRout IRin Gra Grb Grc Rin Rout BAout Cout Yin Zin Zlowout Zhighout HIin LOin read write.
REQ-012 SHALL have alu_op, output, OPCODE_W, ALU operation, valid while Zin=1, else 0.
REQ-013 SHALL have status outputs run, halted, fault, illegal (1 bit each), instr_count (COUNT_W), and state (5 bits, debug).

Function
REQ-014 SHALL drive all strobes as Moore decodes of the present state; every strobe not listed for a state is 0.
REQ-015 SHALL use states IDLE, T0, T1, T2, T3, E1..E5, HALT.
REQ-016 IDLE: run=0. start=1 -> T0.
REQ-017 T0: PCout MARin IncPC Zin, alu_op=00011 -> T1.
REQ-018 T1: Zlowout PCin read -> T2.
REQ-019 T2: read MDRin. Hold while mem_ready=0; mem_ready=1 -> T3.
REQ-020 T3: MDRout IRin. instr_count increments by 1 and wraps modulo 2^COUNT_W -> E1.
REQ-021 Decode in E1 from opcode: ld 00000, ldi 00001, st 00010, ALU 00011..01000, mul/div 01111..10000, nop 11010, halt 11011. Any other opcode -> HALT with illegal=1.
REQ-022 ld: E1 Grb BAout Yin; E2 Cout Zin alu_op=00011; E3 Zlowout MARin; E4 read MDRin, wait on mem_ready; E5 MDRout Gra Rin.
REQ-023 ldi: E1 Grb BAout Yin; E2 Cout Zin alu_op=00011; E3 Zlowout Gra Rin.
REQ-024 st: E1–E3 as ld; E4 Gra Rout MDRin; E5 write, wait on mem_ready.
REQ-025 ALU: E1 Grb Rout Yin; E2 Grc Rout Zin alu_op=opcode; E3 Zlowout Gra Rin.
REQ-026 mul/div: E1 Gra Rout Yin; E2 Grb Rout Zin alu_op=opcode; E3 Zlowout LOin; E4 Zhighout HIin.
REQ-027 nop: E1 asserts no strobes and is the last state.
REQ-028 halt: E1 -> HALT.
REQ-029 Last state of an instruction: go to IDLE if stop=1, else T0. stop is ignored in all other states.
REQ-030 Wait states are T2, ld E4 and st E5. A saturating wait counter resets on entry and increments each cycle mem_ready=0. Reaching MEM_TIMEOUT -> HALT with fault=1; the strobes are dropped the same cycle.
REQ-031 mem_ready=1 on the entry cycle of a wait state completes it in one cycle. mem_ready outside wait states is ignored.
REQ-032 HALT: halted=1, all strobes 0. Exit only via clear; start is ignored.
REQ-033 run=1 in every state except IDLE and HALT.

Reset
REQ-034 clear=0 SHALL asynchronously force IDLE, all strobes 0, alu_op=0, run=halted=fault=illegal=0, instr_count=0 and wait counter 0, including mid-instruction or mid-wait.
REQ-035 After clear rises, the first transition SHALL occur only on a clock edge with start=1.

Verification
REQ-036 Test reset then start. Stimulus: ir=ld (opcode 00000), mem_ready=1 always. Required: state sequence T0,T1,T2,T3,E1..E5,T0; Gra&Rin only in E5; instr_count=1.
REQ-037 Test fetch wait. Stimulus: mem_ready held 0 for 3 cycles in T2. Required: T2 lasts 4 cycles with read=MDRin=1 throughout, then T3.
REQ-038 Test timeout. Stimulus: MEM_TIMEOUT=4, mem_ready=0 forever. Required: HALT with fault=1 after 4 cycles in T2; start ignored; clear recovers to IDLE.
REQ-039 Test ALU op. Stimulus: opcode 00100. Required: alu_op=00100 only in E2; E3 Zlowout Gra Rin; next state T0.
REQ-040 Test illegal opcode and stop. Stimulus: opcode 11111 leads to HALT with illegal=1. Then, after clear: stop=1 during an ALU E3 leads to IDLE; stop=1 during E1 alone does not.
REQ-041 Test counter wrap. Stimulus: COUNT_W=2, five nop instructions. Required: instr_count reads 1,2,3,0,1.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/decode/execute sequencer producing Moore-decoded datapath strobes,
// with a bounded memory handshake that halts on timeout or on an undefined opcode.
module control_sequencer #(
  parameter int unsigned IR_W        = 32,
  parameter int unsigned OPCODE_W    = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                stop,
  input  logic [IR_W-1:0]     ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Cout,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic                read,
  output logic                write,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                run,
  output logic                halted,
  output logic                fault,
  output logic                illegal,
  output logic [COUNT_W-1:0]  instr_count,
  output logic [4:0]          state
);

  typedef enum logic [4:0] {
    S_IDLE = 5'd0,
    S_T0   = 5'd1,
    S_T1   = 5'd2,
    S_T2   = 5'd3,
    S_T3   = 5'd4,
    S_E1   = 5'd5,
    S_E2   = 5'd6,
    S_E3   = 5'd7,
    S_E4   = 5'd8,
    S_E5   = 5'd9,
    S_HALT = 5'd10
  } state_e;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_MD, C_NOP, C_HLT, C_ILL
  } cls_e;

  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(3);

  function automatic cls_e decode(input logic [OPCODE_W-1:0] op);
    if (op == OPCODE_W'(0))                           return C_LD;
    if (op == OPCODE_W'(1))                           return C_LDI;
    if (op == OPCODE_W'(2))                           return C_ST;
    if (op >= OPCODE_W'(3) && op <= OPCODE_W'(8))     return C_ALU;
    if (op == OPCODE_W'(15) || op == OPCODE_W'(16))   return C_MD;
    if (op == OPCODE_W'(26))                          return C_NOP;
    if (op == OPCODE_W'(27))                          return C_HLT;
    return C_ILL;
  endfunction

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d, cur_cls;
  logic [OPCODE_W-1:0]  op_q, op_d;
  logic [7:0]           wait_q, wait_d, wait_inc;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 fault_q, fault_d, illegal_q, illegal_d;
  logic                 is_wait, last;
  logic [OPCODE_W-1:0]  opcode;
  logic                 unused_ir;

  assign opcode    = ir[IR_W-1 -: OPCODE_W];
  assign unused_ir = ^ir;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NOP;
      op_q      <= '0;
      wait_q    <= '0;
      count_q   <= '0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      fault_q   <= fault_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    op_d      = op_q;
    wait_d    = '0;
    count_d   = count_q;
    fault_d   = fault_q;
    illegal_d = illegal_q;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout,
     BAout, Cout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, read, write} = '0;
    alu_op    = '0;
    last      = 1'b0;
    // ir is only trusted from E1 on; later execute states use the class latched in E1
    cur_cls   = (state_q == S_E1) ? decode(opcode) : cls_q;
    is_wait   = (state_q == S_T2) || (state_q == S_E4 && cur_cls == C_LD) ||
                (state_q == S_E5 && cur_cls == C_ST);
    wait_inc  = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; read = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        read = 1'b1; MDRin = 1'b1;
        if (mem_ready) state_d = S_T3;
      end
      S_T3: begin
        MDRout = 1'b1; IRin = 1'b1;
        count_d = count_q + COUNT_W'(1);
        state_d = S_E1;
      end
      S_E1: begin
        cls_d   = cur_cls;
        op_d    = opcode;
        state_d = S_E2;
        case (cur_cls)
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_ALU:             begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_MD:              begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_NOP:             last = 1'b1;
          C_HLT:             state_d = S_HALT;
          default:           begin state_d = S_HALT; illegal_d = 1'b1; end
        endcase
      end
      S_E2: begin
        state_d = S_E3;
        case (cls_q)
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
          C_ALU:             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q; end
          C_MD:              begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q; end
          default:           state_d = S_IDLE;
        endcase
      end
      S_E3: begin
        Zlowout = 1'b1;
        state_d = S_E4;
        case (cls_q)
          C_LD, C_ST:   MARin = 1'b1;
          C_LDI, C_ALU: begin Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
          C_MD:         LOin = 1'b1;
          default:      state_d = S_IDLE;
        endcase
      end
      S_E4: begin
        case (cls_q)
          C_LD:    begin read = 1'b1; MDRin = 1'b1; if (mem_ready) state_d = S_E5; end
          C_ST:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = S_E5; end
          C_MD:    begin Zhighout = 1'b1; HIin = 1'b1; last = 1'b1; end
          default: state_d = S_IDLE;
        endcase
      end
      S_E5: begin
        case (cls_q)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
          C_ST:    begin write = 1'b1; last = mem_ready; end
          default: state_d = S_IDLE;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (last) state_d = stop ? S_IDLE : S_T0;

    // timeout overrides whatever the wait state decided for this cycle
    if (is_wait && !mem_ready) begin
      wait_d = wait_inc;
      if (wait_inc == 8'(MEM_TIMEOUT)) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    end
  end

  assign run         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign fault       = fault_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against an instruction-level plan model.
module tb_control_sequencer;
  localparam int TIMEOUT = 4;
  localparam int CW      = 2;

  localparam logic [4:0] ST_IDLE = 5'd0, ST_T0 = 5'd1, ST_T1 = 5'd2, ST_T2 = 5'd3, ST_T3 = 5'd4,
                         ST_E1 = 5'd5, ST_E2 = 5'd6, ST_E3 = 5'd7, ST_E4 = 5'd8, ST_E5 = 5'd9,
                         ST_HALT = 5'd10;

  localparam logic [21:0] B_PCOUT = 22'd1 << 21, B_PCIN = 22'd1 << 20, B_INCPC = 22'd1 << 19,
    B_MARIN = 22'd1 << 18, B_MDRIN = 22'd1 << 17, B_MDROUT = 22'd1 << 16, B_IRIN = 22'd1 << 15,
    B_GRA = 22'd1 << 14, B_GRB = 22'd1 << 13, B_GRC = 22'd1 << 12, B_RIN = 22'd1 << 11,
    B_ROUT = 22'd1 << 10, B_BAOUT = 22'd1 << 9, B_COUT = 22'd1 << 8, B_YIN = 22'd1 << 7,
    B_ZIN = 22'd1 << 6, B_ZLOW = 22'd1 << 5, B_ZHIGH = 22'd1 << 4, B_HIIN = 22'd1 << 3,
    B_LOIN = 22'd1 << 2, B_READ = 22'd1 << 1, B_WRITE = 22'd1;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic start = 1'b0, stop = 1'b0, mem_ready = 1'b1;
  logic [31:0] ir = '0;
  logic [31:0] next_word = '0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout;
  logic BAout, Cout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, read, write;
  logic [4:0] alu_op;
  logic run, halted, fault, illegal;
  logic [CW-1:0] instr_count;
  logic [4:0] state;
  logic [21:0] strb;

  control_sequencer #(.IR_W(32), .OPCODE_W(5), .MEM_TIMEOUT(TIMEOUT), .COUNT_W(CW)) dut (
    .clock(clock), .clear(clear), .start(start), .stop(stop), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
    .LOin(LOin), .read(read), .write(write), .alu_op(alu_op), .run(run), .halted(halted),
    .fault(fault), .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  assign strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout,
                 BAout, Cout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, read, write};

  always #5 clock = ~clock;

  // instruction register of the surrounding datapath
  always @(posedge clock) if (IRin) ir <= next_word;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0]  st;
    logic [21:0] strb;
    logic [4:0]  aop;
    logic        wt;
    logic        last;
    logic [1:0]  kind;   // 0 normal, 1 halt, 2 illegal
  } step_t;

  step_t plan[$];
  int    mode = 0;       // 0 idle, 1 running, 2 halted
  int    waitc = 0;
  int    m_count = 0;
  bit    m_fault = 1'b0, m_ill = 1'b0;

  task automatic push_step(input logic [4:0] st, input logic [21:0] s, input logic [4:0] a,
                           input logic wt, input logic last, input logic [1:0] kind);
    step_t x;
    x.st = st; x.strb = s; x.aop = a; x.wt = wt; x.last = last; x.kind = kind;
    plan.push_back(x);
  endtask

  task automatic plan_fetch();
    plan.delete();
    push_step(ST_T0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 5'd3, 1'b0, 1'b0, 2'd0);
    push_step(ST_T1, B_ZLOW | B_PCIN | B_READ,            5'd0, 1'b0, 1'b0, 2'd0);
    push_step(ST_T2, B_READ | B_MDRIN,                    5'd0, 1'b1, 1'b0, 2'd0);
    push_step(ST_T3, B_MDROUT | B_IRIN,                   5'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic plan_exec(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd1 || op == 5'd2) begin
      push_step(ST_E1, B_GRB | B_BAOUT | B_YIN, 5'd0, 1'b0, 1'b0, 2'd0);
      push_step(ST_E2, B_COUT | B_ZIN,          5'd3, 1'b0, 1'b0, 2'd0);
      if (op == 5'd1) push_step(ST_E3, B_ZLOW | B_GRA | B_RIN, 5'd0, 1'b0, 1'b1, 2'd0);
      else begin
        push_step(ST_E3, B_ZLOW | B_MARIN, 5'd0, 1'b0, 1'b0, 2'd0);
        if (op == 5'd0) begin
          push_step(ST_E4, B_READ | B_MDRIN,          5'd0, 1'b1, 1'b0, 2'd0);
          push_step(ST_E5, B_MDROUT | B_GRA | B_RIN,  5'd0, 1'b0, 1'b1, 2'd0);
        end else begin
          push_step(ST_E4, B_GRA | B_ROUT | B_MDRIN,  5'd0, 1'b0, 1'b0, 2'd0);
          push_step(ST_E5, B_WRITE,                   5'd0, 1'b1, 1'b1, 2'd0);
        end
      end
    end else if (op >= 5'd3 && op <= 5'd8) begin
      push_step(ST_E1, B_GRB | B_ROUT | B_YIN, 5'd0, 1'b0, 1'b0, 2'd0);
      push_step(ST_E2, B_GRC | B_ROUT | B_ZIN, op,   1'b0, 1'b0, 2'd0);
      push_step(ST_E3, B_ZLOW | B_GRA | B_RIN, 5'd0, 1'b0, 1'b1, 2'd0);
    end else if (op == 5'd15 || op == 5'd16) begin
      push_step(ST_E1, B_GRA | B_ROUT | B_YIN, 5'd0, 1'b0, 1'b0, 2'd0);
      push_step(ST_E2, B_GRB | B_ROUT | B_ZIN, op,   1'b0, 1'b0, 2'd0);
      push_step(ST_E3, B_ZLOW | B_LOIN,        5'd0, 1'b0, 1'b0, 2'd0);
      push_step(ST_E4, B_ZHIGH | B_HIIN,       5'd0, 1'b0, 1'b1, 2'd0);
    end else if (op == 5'd26) push_step(ST_E1, 22'd0, 5'd0, 1'b0, 1'b1, 2'd0);
    else if (op == 5'd27)     push_step(ST_E1, 22'd0, 5'd0, 1'b0, 1'b0, 2'd1);
    else                      push_step(ST_E1, 22'd0, 5'd0, 1'b0, 1'b0, 2'd2);
  endtask

  task automatic model_reset();
    mode = 0; plan.delete(); waitc = 0; m_count = 0; m_fault = 1'b0; m_ill = 1'b0;
  endtask

  task automatic model_step();
    step_t cur;
    if (mode == 0) begin
      if (start) begin mode = 1; plan_fetch(); end
      return;
    end
    if (mode == 2 || plan.size() == 0) return;
    cur = plan[0];
    if (cur.wt && !mem_ready) begin
      waitc++;
      if (waitc == TIMEOUT) begin mode = 2; m_fault = 1'b1; plan.delete(); end
      return;
    end
    waitc = 0;
    void'(plan.pop_front());
    if (cur.kind != 2'd0) begin
      mode = 2;
      if (cur.kind == 2'd2) m_ill = 1'b1;
      plan.delete();
    end else if (cur.st == ST_T3) begin
      m_count = (m_count + 1) % (1 << CW);
      plan_exec(next_word[31:27]);
    end else if (cur.last) begin
      if (stop) begin mode = 0; plan.delete(); end
      else plan_fetch();
    end
  endtask

  always @(posedge clock or negedge clear) begin
    if (!clear) model_reset();
    else model_step();
  end

  bit           chk_en = 1'b0;
  logic [4:0]   e_st, e_a;
  logic [21:0]  e_s;
  logic         e_run, e_halt;
  logic [CW-1:0] e_cnt;

  always @(negedge clock) begin
    if (chk_en) begin
      e_s = '0; e_a = '0; e_run = 1'b0; e_halt = 1'b0; e_st = ST_IDLE;
      if (mode == 1) begin
        if (plan.size() > 0) begin
          e_st = plan[0].st; e_s = plan[0].strb; e_a = plan[0].aop; e_run = 1'b1;
        end else e_st = 5'h1f;
      end else if (mode == 2) begin
        e_st = ST_HALT; e_halt = 1'b1;
      end
      e_cnt = m_count[CW-1:0];
      tests++;
      if ({state, strb, alu_op, run, halted, fault, illegal, instr_count} !==
          {e_st, e_s, e_a, e_run, e_halt, m_fault, m_ill, e_cnt}) begin
        fails++;
        $display("FAIL model t=%0t actual/required: state %0d/%0d strobes %h/%h alu_op %0d/%0d run %b/%b halted %b/%b fault %b/%b illegal %b/%b count %0d/%0d",
                 $time, state, e_st, strb, e_s, alu_op, e_a, run, e_run, halted, e_halt,
                 fault, m_fault, illegal, m_ill, instr_count, e_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_for(input logic [4:0] code, input string name);
    int n = 0;
    while (state !== code && n < 60) begin cyc(); n++; end
    chk(name, 32'(state), 32'(code));
  endtask

  logic [4:0] seq_ld [10];
  logic [4:0] seq_alu [8];
  logic [4:0] aop_alu [8];
  logic [CW-1:0] cnt_seq [5];
  logic [4:0] legal [12];

  initial begin
    int hcnt;
    int r;
    logic [4:0] op;
    seq_ld  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd1};
    seq_alu = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd1};
    aop_alu = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd3};
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    legal   = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd15, 5'd16, 5'd26};

    #1 clear = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_run", 32'(run), 32'd0);
    chk("reset_strobes", 32'(strb), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);

    // load instruction with an always-ready memory
    next_word = {5'b00000, 27'd0};
    clear = 1'b1; cyc();
    chk("idle_without_start", 32'(state), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      chk("ld_sequence", 32'(state), 32'(seq_ld[i]));
      chk("ld_gra_rin", 32'(Gra & Rin), 32'(i == 8));
    end
    chk("ld_count", 32'(instr_count), 32'd1);

    // fetch wait: three not-ready cycles stretch T2 to four cycles
    wait_for(ST_T2, "reach_t2");
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      chk("t2_hold", 32'(state), 32'(ST_T2));
      chk("t2_read_mdrin", 32'(read & MDRin), 32'd1);
    end
    mem_ready = 1'b1; cyc();
    chk("t2_to_t3", 32'(state), 32'(ST_T3));

    // timeout in T2
    wait_for(ST_T2, "reach_t2_timeout");
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("timeout_t2_hold", 32'(state), 32'(ST_T2));
    end
    cyc();
    chk("timeout_halt", 32'(state), 32'(ST_HALT));
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_halted", 32'(halted), 32'd1);
    chk("timeout_strobes", 32'(strb), 32'd0);
    start = 1'b1; cyc(); cyc(); start = 1'b0;
    chk("halt_ignores_start", 32'(state), 32'(ST_HALT));
    clear = 1'b0; #1;
    chk("async_clear_state", 32'(state), 32'd0);
    chk("async_clear_fault", 32'(fault), 32'd0);
    chk("async_clear_count", 32'(instr_count), 32'd0);
    cyc(); clear = 1'b1; mem_ready = 1'b1; cyc();
    chk("clear_stays_idle", 32'(state), 32'd0);

    // ALU opcode 00100
    next_word = {5'b00100, 27'd0};
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      chk("alu_sequence", 32'(state), 32'(seq_alu[i]));
      chk("alu_op", 32'(alu_op), 32'(aop_alu[i]));
      if (i == 6) chk("alu_e3_strobes", 32'(Zlowout & Gra & Rin), 32'd1);
    end

    // illegal opcode
    next_word = {5'b11111, 27'd0};
    wait_for(ST_E1, "reach_e1_illegal");
    cyc();
    chk("illegal_halt", 32'(state), 32'(ST_HALT));
    chk("illegal_flag", 32'(illegal), 32'd1);
    chk("illegal_no_fault", 32'(fault), 32'd0);
    clear = 1'b0; cyc(); clear = 1'b1;
    chk("illegal_cleared", 32'(illegal), 32'd0);

    // stop honoured only at the instruction boundary
    next_word = {5'b00011, 27'd0};
    start = 1'b1; cyc(); start = 1'b0;
    wait_for(ST_E1, "reach_e1_stop");
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_in_e1_ignored", 32'(state), 32'(ST_E2));
    cyc(); cyc();
    chk("no_stop_to_t0", 32'(state), 32'(ST_T0));
    wait_for(ST_E3, "reach_e3_stop");
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_in_e3_idle", 32'(state), 32'(ST_IDLE));

    // halt opcode
    next_word = {5'b11011, 27'd0};
    start = 1'b1; cyc(); start = 1'b0;
    wait_for(ST_E1, "reach_e1_halt");
    cyc();
    chk("halt_op_state", 32'(state), 32'(ST_HALT));
    chk("halt_op_not_illegal", 32'(illegal), 32'd0);
    clear = 1'b0; cyc(); clear = 1'b1;

    // counter wrap with five nops
    next_word = {5'b11010, 27'd0};
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_for(ST_E1, "reach_e1_nop");
      chk("nop_count", 32'(instr_count), 32'(cnt_seq[k]));
      if (k == 4) stop = 1'b1;
      cyc();
      stop = 1'b0;
    end
    chk("nop_stop_idle", 32'(state), 32'(ST_IDLE));

    // randomized traffic
    hcnt = 0;
    clear = 1'b0; cyc(); clear = 1'b1;
    repeat (3000) begin
      start     = ($urandom_range(0, 9) < 3);
      stop      = ($urandom_range(0, 9) < 2);
      mem_ready = ($urandom_range(0, 99) < 75);
      r = int'($urandom_range(0, 99));
      if (r < 2)      op = 5'd27;
      else if (r < 4) op = 5'($urandom_range(17, 25));
      else            op = legal[$urandom_range(0, 11)];
      next_word = {op, 27'($urandom)};
      hcnt = (mode == 2) ? hcnt + 1 : 0;
      if (hcnt > 3 || $urandom_range(0, 199) == 0) begin
        clear = 1'b0; cyc(); clear = 1'b1; hcnt = 0;
      end
      cyc();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
